// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-channel streaming multiplexer.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Pointer advance that wraps for any channel count, not only powers of two.
  function automatic int ptr_inc(input int idx, input int nch);
    return (idx == nch - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_nbit.sv
// Combinational rotating-priority finder: first set request at or after ptr_i, wrapping.
module rr_arbiter_nbit #(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [SELW-1:0] grant_o,
  output logic            grant_valid_o
);

  logic [SELW-1:0] idx;

  // Scan from the farthest offset back to ptr_i so the closest request wins.
  always_comb begin
    grant_o       = '0;
    grant_valid_o = 1'b0;
    idx           = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = SELW'((int'(ptr_i) + i) % NCH);
      if (req_i[idx]) begin
        grant_o       = idx;
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_stream_rr.sv
// N-channel streaming mux with fixed-select or round-robin grant and one registered output stage.
module mux_nx1_stream_rr
  import mux_pkg::*;
#(
  parameter int  n    = 4,
  parameter int  NCH  = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic            clk_in,
  input  logic            reset_n_in,
  input  logic [NCH*n-1:0] w_in,
  input  logic [NCH-1:0]  valid_in,
  output logic [NCH-1:0]  ready_out,
  input  logic            mode_in,
  input  logic [SELW-1:0] s_in,
  output logic [n-1:0]    f_out,
  output logic [SELW-1:0] ch_out,
  output logic            valid_out,
  input  logic            ready_in
);

  logic [n-1:0]        f_q;
  logic [SELW-1:0]     ch_q;
  logic                valid_q;
  logic [SELW-1:0]     ptr_q;
  logic [SELW-1:0]     rr_grant;
  logic                rr_valid;
  logic [SELW-1:0]     grant;
  logic                grant_valid;
  logic                fix_valid;
  logic                load;
  logic                xfer;
  logic [2**SELW-1:0]  valid_pad;
  logic [n-1:0]        grant_data;

  rr_arbiter_nbit #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .req_i         (valid_in),
    .ptr_i         (ptr_q),
    .grant_o       (rr_grant),
    .grant_valid_o (rr_valid)
  );

  always_comb begin
    // Zero-padding makes an out-of-range select read as "not valid".
    valid_pad            = '0;
    valid_pad[NCH-1:0]   = valid_in;
    fix_valid            = valid_pad[s_in];

    if (mode_in == MODE_RR) begin
      grant       = rr_grant;
      grant_valid = rr_valid;
    end else begin
      grant       = s_in;
      grant_valid = fix_valid;
    end

    load = !valid_q || ready_in;
    xfer = load && grant_valid && reset_n_in;

    ready_out  = '0;
    grant_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant == SELW'(k)) begin
        ready_out[k] = xfer;
        grant_data   = w_in[k*n +: n];
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      f_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else if (xfer) begin
      f_q     <= grant_data;
      ch_q    <= grant;
      valid_q <= 1'b1;
      ptr_q   <= SELW'(ptr_inc(int'(grant), NCH));
    end else if (load) begin
      valid_q <= 1'b0;
    end
  end

  assign f_out     = f_q;
  assign ch_out    = ch_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_mux_nx1_stream_rr.sv
// Scoreboard bench for mux_nx1_stream_rr: directed scenarios plus randomized traffic.
module tb_mux_nx1_stream_rr;

  localparam int N    = 4;
  localparam int NCH  = 4;
  localparam int SELW = 2;
  localparam int W    = NCH * N;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0]    w;
  logic [NCH-1:0]  valid;
  logic [NCH-1:0]  ready_out;
  logic            mode;
  logic [SELW-1:0] s;
  logic [N-1:0]    f;
  logic [SELW-1:0] ch;
  logic            vout;
  logic            rdy;

  logic [11:0] w3;
  logic [2:0]  valid3;
  logic [2:0]  ready3;
  logic        mode3;
  logic [1:0]  s3;
  logic [3:0]  f3;
  logic [1:0]  ch3;
  logic        vout3;
  logic        rdy3;

  mux_nx1_stream_rr #(.n(N), .NCH(NCH)) dut (
    .clk_in     (clk),
    .reset_n_in (rst_n),
    .w_in       (w),
    .valid_in   (valid),
    .ready_out  (ready_out),
    .mode_in    (mode),
    .s_in       (s),
    .f_out      (f),
    .ch_out     (ch),
    .valid_out  (vout),
    .ready_in   (rdy)
  );

  mux_nx1_stream_rr #(.n(4), .NCH(3)) dut3 (
    .clk_in     (clk),
    .reset_n_in (rst_n),
    .w_in       (w3),
    .valid_in   (valid3),
    .ready_out  (ready3),
    .mode_in    (mode3),
    .s_in       (s3),
    .f_out      (f3),
    .ch_out     (ch3),
    .valid_out  (vout3),
    .ready_in   (rdy3)
  );

  typedef struct {
    logic [N-1:0] d;
    int           c;
  } beat_t;

  beat_t exp_q[$];
  int    m_ptr   = 0;
  bit    m_valid = 1'b0;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant straight from the rules: fixed select, or first valid channel scanning from ptr.
  function automatic int model_grant(input logic [NCH-1:0] v, input logic m, input int sel,
                                     input int p);
    if (m == 1'b0) begin
      if (sel < NCH && ((v >> sel) & 1) != 0) return sel;
      return -1;
    end
    for (int i = 0; i < NCH; i++) begin
      if (((v >> ((p + i) % NCH)) & 1) != 0) return (p + i) % NCH;
    end
    return -1;
  endfunction

  // Negedge half: check handshake against the model and record what will be loaded.
  task automatic half_a();
    int          g;
    bit          ld;
    logic [31:0] exp_r;
    beat_t       b;
    @(negedge clk);
    g  = model_grant(valid, mode, int'(s), m_ptr);
    ld = !m_valid || rdy;
    chk("valid_out", 32'(vout), 32'(m_valid));
    exp_r = (g >= 0 && ld) ? (32'd1 << g) : 32'd0;
    chk("ready_out", 32'(ready_out), exp_r);
    if (g >= 0 && ld) begin
      b.d = w[g*N +: N];
      b.c = g;
      exp_q.push_back(b);
      m_ptr   = (g + 1) % NCH;
      m_valid = 1'b1;
    end else if (ld) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic half_b();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    half_a();
    half_b();
  endtask

  // Monitor: every consumed beat must match the oldest expected one.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && vout === 1'b1 && rdy === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got f=%0h ch=%0d expected no beat", f, ch);
        end else begin
          b = exp_q.pop_front();
          chk("f_out", 32'(f), 32'(b.d));
          chk("ch_out", 32'(ch), 32'(b.c));
        end
      end
    end
  end

  initial begin
    w = '0; valid = '0; mode = 1'b0; s = '0; rdy = 1'b1;
    w3 = 12'h987; valid3 = '0; mode3 = 1'b0; s3 = '0; rdy3 = 1'b1;

    #1 rst_n = 1'b0;
    valid = 4'b1111; mode = 1'b1;
    #3;
    chk("rst_f", 32'(f), 0);
    chk("rst_valid", 32'(vout), 0);
    chk("rst_ch", 32'(ch), 0);
    chk("rst_ready", 32'(ready_out), 0);
    valid = '0; mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    half_b();

    // NCH=3: reach ptr=2, then wrap to 0 and on to 1; out-of-range select never grants.
    mode3 = 1'b0; s3 = 2'd1; valid3 = 3'b010;
    half_a(); chk("nch3_fix_ready", 32'(ready3), 32'b010); half_b();
    mode3 = 1'b1; valid3 = 3'b011;
    half_a(); chk("nch3_wrap_grant0", 32'(ready3), 32'b001); chk("nch3_f1", 32'(f3), 8); half_b();
    half_a(); chk("nch3_next_grant1", 32'(ready3), 32'b010); chk("nch3_ch0", 32'(ch3), 0);
    chk("nch3_f0", 32'(f3), 7); half_b();
    mode3 = 1'b0; s3 = 2'd3; valid3 = 3'b111;
    half_a(); chk("nch3_oob_ready", 32'(ready3), 0); chk("nch3_ch1", 32'(ch3), 1); half_b();
    valid3 = '0;
    half_a(); chk("nch3_valid_fall", 32'(vout3), 0); chk("nch3_ch_hold", 32'(ch3), 1); half_b();

    // Round-robin fairness from ptr=0.
    mode = 1'b1; valid = 4'b1111; rdy = 1'b1; w = 16'h4321;
    repeat (6) cycle();

    // Fixed select on channel 2, then a select whose channel is idle.
    mode = 1'b0; s = 2'd2; valid = 4'b0110; w = 16'h0500;
    half_a(); chk("fix_ready", 32'(ready_out), 32'b0100); half_b();
    s = 2'd3;
    half_a(); chk("fix_f", 32'(f), 5); chk("fix_ch", 32'(ch), 2); chk("fix_idle_ready", 32'(ready_out), 0);
    half_b();
    cycle();

    // ptr is 3 now; switching to fixed select 0 must grant channel 0.
    mode = 1'b0; s = 2'd0; valid = 4'b1001; w = 16'h7006;
    half_a(); chk("mode_switch_ready", 32'(ready_out), 32'b0001); half_b();
    mode = 1'b1; valid = 4'b1111;
    half_a(); chk("ptr_after_switch", 32'(ready_out), 32'b0010); half_b();

    // Backpressure on a held 4'h3 beat, then consume-and-refill in one cycle.
    mode = 1'b0; s = 2'd0; valid = 4'b0001; w = 16'h0003;
    cycle();
    rdy = 1'b0; mode = 1'b1; valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      w = W'($urandom);
      half_a();
      chk("bp_f", 32'(f), 3); chk("bp_valid", 32'(vout), 1); chk("bp_ready", 32'(ready_out), 0);
      half_b();
    end
    rdy = 1'b1;
    cycle();
    cycle();

    // Asynchronous reset with a 4'hA beat held.
    mode = 1'b0; s = 2'd1; valid = 4'b0010; w = 16'h00A0; rdy = 1'b1;
    cycle();
    rdy = 1'b0; valid = '0;
    cycle();
    chk("held_A", 32'(f), 32'hA);
    #2 rst_n = 1'b0;
    valid = 4'b1111; mode = 1'b1;
    #1;
    chk("async_rst_f", 32'(f), 0);
    chk("async_rst_valid", 32'(vout), 0);
    chk("async_rst_ready", 32'(ready_out), 0);
    exp_q.delete(); m_valid = 1'b0; m_ptr = 0;
    half_b();
    chk("rst_hold_ready", 32'(ready_out), 0);
    valid = '0; mode = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    half_b();
    cycle();
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      w     = W'($urandom);
      valid = NCH'($urandom);
      mode  = 1'($urandom);
      s     = SELW'($urandom);
      rdy   = ($urandom_range(0, 3) != 0);
      cycle();
    end

    rdy = 1'b1; valid = '0;
    cycle();
    cycle();
    chk("drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
